// File: rtl/stall_tracker.sv
// Bubble injector and EX/MEM/WB destination tracker for the 5-stage core.
// Holds IF/ID on stall, squashes it on flush, and counts stall cycles and over-long stall runs.
module stall_tracker #(
   parameter logic [15:0] NOP_INST  = 16'h0800,
   parameter int unsigned MAX_STALL = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] instIn,
   input  logic        sendNOP,
   input  logic        flush,
   input  logic [2:0]  destID,
   input  logic        regWriteID,
   input  logic        BranchID,
   output logic [15:0] instID,
   output logic        pcWrite,
   output logic [2:0]  execute,
   output logic [2:0]  memory,
   output logic [2:0]  writeback,
   output logic        NOPEx,
   output logic        NOPMem,
   output logic        NOPWB,
   output logic        BranchEx,
   output logic [15:0] stallCycles,
   output logic        stallErr
);

   logic [15:0] inst_q, inst_d;
   logic [2:0]  ex_dest_q, ex_dest_d;
   logic [2:0]  mem_dest_q, mem_dest_d;
   logic [2:0]  wb_dest_q, wb_dest_d;
   logic        ex_vld_q, ex_vld_d;
   logic        mem_vld_q, mem_vld_d;
   logic        wb_vld_q, wb_vld_d;
   logic        ex_br_q, ex_br_d;
   logic [15:0] cnt_q, cnt_d;
   logic [2:0]  run_q, run_d;
   logic        err_q, err_d;

   logic stall_cyc;
   logic bubble;
   logic id_real;

   // A stall cycle only counts when no flush overrides it.
   assign stall_cyc = ~sendNOP & ~flush;
   assign bubble    = flush | ~sendNOP;
   assign id_real   = (inst_q != NOP_INST);

   always_comb begin
      inst_d     = inst_q;
      ex_dest_d  = ex_dest_q;
      ex_vld_d   = ex_vld_q;
      ex_br_d    = ex_br_q;
      mem_dest_d = ex_dest_q;
      mem_vld_d  = ex_vld_q;
      wb_dest_d  = mem_dest_q;
      wb_vld_d   = mem_vld_q;
      cnt_d      = cnt_q;
      run_d      = run_q;
      err_d      = err_q;

      if (bubble) begin
         ex_dest_d = 3'd0;
         ex_vld_d  = 1'b0;
         ex_br_d   = 1'b0;
      end else begin
         ex_dest_d = destID;
         ex_vld_d  = regWriteID & id_real;
         ex_br_d   = BranchID & id_real;
      end

      if (flush)
         inst_d = NOP_INST;
      else if (sendNOP)
         inst_d = instIn;

      if (stall_cyc) begin
         if (cnt_q != 16'hFFFF)
            cnt_d = cnt_q + 16'd1;
         if (run_q != 3'd7)
            run_d = run_q + 3'd1;
         // The run length this cycle would reach is run_q+1.
         if ((32'(run_q) + 32'd1) > MAX_STALL)
            err_d = 1'b1;
      end else begin
         run_d = 3'd0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inst_q     <= NOP_INST;
         ex_dest_q  <= 3'd0;
         mem_dest_q <= 3'd0;
         wb_dest_q  <= 3'd0;
         ex_vld_q   <= 1'b0;
         mem_vld_q  <= 1'b0;
         wb_vld_q   <= 1'b0;
         ex_br_q    <= 1'b0;
         cnt_q      <= 16'd0;
         run_q      <= 3'd0;
         err_q      <= 1'b0;
      end else begin
         inst_q     <= inst_d;
         ex_dest_q  <= ex_dest_d;
         mem_dest_q <= mem_dest_d;
         wb_dest_q  <= wb_dest_d;
         ex_vld_q   <= ex_vld_d;
         mem_vld_q  <= mem_vld_d;
         wb_vld_q   <= wb_vld_d;
         ex_br_q    <= ex_br_d;
         cnt_q      <= cnt_d;
         run_q      <= run_d;
         err_q      <= err_d;
      end
   end

   // Flush must let the redirected PC load even if decode asked to stall.
   assign pcWrite     = sendNOP | flush;
   assign instID      = inst_q;
   assign execute     = ex_dest_q;
   assign memory      = mem_dest_q;
   assign writeback   = wb_dest_q;
   assign NOPEx       = ex_vld_q;
   assign NOPMem      = mem_vld_q;
   assign NOPWB       = wb_vld_q;
   assign BranchEx    = ex_br_q;
   assign stallCycles = cnt_q;
   assign stallErr    = err_q;

endmodule

// File: tb/tb_stall_tracker.sv
// Bench for stall_tracker: in-flight history model checked every cycle, plus directed literal checks.
module tb_stall_tracker;

   localparam logic [15:0] NOP = 16'h0800;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] instIn;
   logic        sendNOP;
   logic        flush;
   logic [2:0]  destID;
   logic        regWriteID;
   logic        BranchID;
   logic [15:0] instID;
   logic        pcWrite;
   logic [2:0]  execute, memory, writeback;
   logic        NOPEx, NOPMem, NOPWB, BranchEx;
   logic [15:0] stallCycles;
   logic        stallErr;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   stall_tracker dut (
      .clk(clk), .rst_n(rst_n), .instIn(instIn), .sendNOP(sendNOP), .flush(flush),
      .destID(destID), .regWriteID(regWriteID), .BranchID(BranchID), .instID(instID),
      .pcWrite(pcWrite), .execute(execute), .memory(memory), .writeback(writeback),
      .NOPEx(NOPEx), .NOPMem(NOPMem), .NOPWB(NOPWB), .BranchEx(BranchEx),
      .stallCycles(stallCycles), .stallErr(stallErr)
   );

   always #5 clk = ~clk;

   // Model: every cycle one entry enters EX; MEM and WB are simply the two entries before it.
   typedef struct packed {
      logic [2:0] d;
      logic       v;
      logic       b;
   } ent_t;

   ent_t        hist[$];
   logic [15:0] m_inst;
   int          m_cnt;
   int          m_run;
   bit          m_err;

   task automatic model_reset();
      hist = {};
      for (int i = 0; i < 3; i++) hist.push_back(ent_t'(0));
      m_inst = NOP;
      m_cnt  = 0;
      m_run  = 0;
      m_err  = 1'b0;
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         model_reset();
      end else begin
         ent_t e;
         bit   stall;
         bit   real_inst;
         stall     = !sendNOP && !flush;
         real_inst = (m_inst != NOP);
         e = ent_t'(0);
         if (sendNOP && !flush) begin
            e.d = destID;
            e.v = regWriteID && real_inst;
            e.b = BranchID && real_inst;
         end
         hist.push_back(e);
         while (hist.size() > 3) void'(hist.pop_front());
         if (flush) m_inst = NOP;
         else if (sendNOP) m_inst = instIn;
         if (stall) begin
            if (m_cnt < 65535) m_cnt++;
            m_run = (m_run < 7) ? m_run + 1 : 7;
            if (m_run > 3) m_err = 1'b1;
         end else begin
            m_run = 0;
         end
      end
   end

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("instID", instID, m_inst);
         chk("pcWrite", 16'(pcWrite), 16'(sendNOP | flush));
         chk("execute", 16'(execute), 16'(hist[2].d));
         chk("memory", 16'(memory), 16'(hist[1].d));
         chk("writeback", 16'(writeback), 16'(hist[0].d));
         chk("NOPEx", 16'(NOPEx), 16'(hist[2].v));
         chk("NOPMem", 16'(NOPMem), 16'(hist[1].v));
         chk("NOPWB", 16'(NOPWB), 16'(hist[0].v));
         chk("BranchEx", 16'(BranchEx), 16'(hist[2].b));
         chk("stallCycles", stallCycles, 16'(m_cnt));
         chk("stallErr", 16'(stallErr), 16'(m_err));
      end
   end

   task automatic set_in(input logic [15:0] inst, input logic snop, input logic fl,
                         input logic [2:0] d, input logic rw, input logic br);
      instIn = inst; sendNOP = snop; flush = fl; destID = d; regWriteID = rw; BranchID = br;
   endtask

   task automatic cyc(input logic [15:0] inst, input logic snop, input logic fl,
                      input logic [2:0] d, input logic rw, input logic br);
      set_in(inst, snop, fl, d, rw, br);
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      set_in(16'h0000, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_instID", instID, 16'h0800);
      chk("rst_stallCycles", stallCycles, 16'h0000);
      rst_n = 1'b1;
      chk_en = 1'b1;

      // Writer r3 walks EX, MEM, WB on successive edges.
      cyc(16'h1234, 1, 0, 3'd0, 0, 0);
      chk("adv_instID", instID, 16'h1234);
      cyc(16'h2345, 1, 0, 3'd3, 1, 0);
      chk("adv_ex", {12'h0, NOPEx, execute}, 16'h000B);
      cyc(16'h3456, 1, 0, 3'd0, 0, 0);
      chk("adv_mem", {12'h0, NOPMem, memory}, 16'h000B);
      cyc(16'h4567, 1, 0, 3'd0, 0, 0);
      chk("adv_wb", {12'h0, NOPWB, writeback}, 16'h000B);

      // Three-cycle stall with fetch still changing.
      for (int i = 0; i < 3; i++) begin
         set_in(16'hA000 + 16'(i), 0, 0, 3'd5, 1, 0);
         #1;
         chk("stall_pcWrite", 16'(pcWrite), 16'h0000);
         @(posedge clk);
         #1;
         chk("stall_NOPEx", 16'(NOPEx), 16'h0000);
      end
      chk("stall_instID_held", instID, 16'h4567);
      chk("stall_count", stallCycles, 16'd3);
      chk("stall_noerr", 16'(stallErr), 16'h0000);
      cyc(16'h5678, 1, 0, 3'd2, 1, 0);
      chk("resume_ex", {12'h0, NOPEx, execute}, 16'h000A);

      // Four consecutive stalls trip the sticky error on the fourth edge.
      for (int i = 0; i < 3; i++) cyc(16'hB000, 0, 0, 3'd1, 1, 0);
      chk("over3_noerr", 16'(stallErr), 16'h0000);
      cyc(16'hB001, 0, 0, 3'd1, 1, 0);
      chk("over4_err", 16'(stallErr), 16'h0001);
      chk("over4_count", stallCycles, 16'd7);
      cyc(16'h6789, 1, 0, 3'd0, 0, 0);
      cyc(16'h789A, 1, 0, 3'd0, 0, 0);
      chk("err_sticky", 16'(stallErr), 16'h0001);

      // Flush wins over a simultaneous stall request.
      set_in(16'hC0DE, 0, 1, 3'd4, 1, 1);
      #1;
      chk("flush_pcWrite", 16'(pcWrite), 16'h0001);
      @(posedge clk);
      #1;
      chk("flush_instID", instID, 16'h0800);
      chk("flush_ex", {13'h0, NOPEx, BranchEx, 1'b0}, 16'h0000);
      chk("flush_count", stallCycles, 16'd7);

      // Branch flag only for a real instruction in ID.
      cyc(16'h5555, 1, 0, 3'd0, 0, 0);
      cyc(16'h0800, 1, 0, 3'd0, 0, 1);
      chk("br_real", 16'(BranchEx), 16'h0001);
      cyc(16'h1111, 1, 0, 3'd0, 0, 1);
      chk("br_nop", 16'(BranchEx), 16'h0000);
      cyc(16'h2222, 1, 0, 3'd6, 1, 0);
      chk("br_clear", 16'(BranchEx), 16'h0000);

      // Mixed directed vectors.
      for (int i = 0; i < 24; i++) begin
         cyc(16'($urandom_range(0, 16'hFFFF)), (i % 5) != 2, (i % 7) == 3,
             3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      // Reset asserted in the middle of a stall.
      cyc(16'hD000, 0, 0, 3'd3, 1, 0);
      set_in(16'hD001, 0, 0, 3'd3, 1, 0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_instID", instID, 16'h0800);
      chk("midrst_count", stallCycles, 16'h0000);
      chk("midrst_flags", {13'h0, NOPEx, NOPMem, NOPWB}, 16'h0000);
      chk("midrst_pcWrite", 16'(pcWrite), 16'h0000);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc(16'hE000, 1, 0, 3'd1, 1, 0);
      chk("postrst_ex", {12'h0, NOPEx, execute}, 16'h0001);

      // Long stall run: counter must saturate, not wrap.
      set_in(16'hF000, 0, 0, 3'd7, 1, 0);
      repeat (65540) @(posedge clk);
      #1;
      chk("sat_count", stallCycles, 16'hFFFF);
      chk("sat_err", 16'(stallErr), 16'h0001);
      cyc(16'hF001, 1, 0, 3'd0, 0, 0);
      cyc(16'hF002, 0, 0, 3'd0, 0, 0);
      chk("sat_hold", stallCycles, 16'hFFFF);

      @(negedge clk);
      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/stall_tracker.md
# stall_tracker

Pipeline bubble and destination tracker for the 5-stage 16-bit core. It consumes the active-low `sendNOP` stall request produced by the decode-stage hazard comparator and holds the IF/ID instruction register. It injects bubbles into execute and tracks each in-flight instruction's destination register, valid (non-NOP) flag and branch flag through EX, MEM and WB. It drives the `execute`/`memory`/`writeback`, `NOPEx`/`NOPMem`/`NOPWB` and `BranchEx` inputs the comparator checks against, closing the hazard loop.

## Interface
- NOP_INST, 16'h0800, encoding loaded into IF/ID on reset and flush
- MAX_STALL, 3, largest legal run of consecutive stall cycles
- clk  input  1  core clock, all state on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- instIn  input  16  instruction from fetch
- sendNOP  input  1  low = stall request from hazard comparator
- flush  input  1  high = taken branch/jump resolved in EX; squash IF/ID and ID
- destID  input  3  destination register decoded from instID
- regWriteID  input  1  instID writes destID
- BranchID  input  1  instID is a branch/jump
- instID  output  16  IF/ID register contents to decode
- pcWrite  output  1  low = fetch must hold PC
- execute, memory, writeback  output  3 each  destination register per stage
- NOPEx, NOPMem, NOPWB  output  1 each  low = stage holds a bubble or non-writing instruction
- BranchEx  output  1  EX holds a branch
- stallCycles  output  16  saturating count of stall cycles since reset
- stallErr  output  1  sticky; stall run exceeded MAX_STALL

## Operation
- Reset (rst_n low, async):
  - instID=NOP_INST.
  - execute/memory/writeback=0.
  - NOPEx/NOPMem/NOPWB=0.
  - BranchEx=0, stallCycles=0, stallErr=0, run counter=0.
- Every cycle MEM→WB and EX→MEM shift unconditionally: writeback<=memory, NOPWB<=NOPMem; memory<=execute, NOPMem<=NOPEx.
- ID→EX, priority flush > stall > advance:
  - flush=1: NOPEx<=0, BranchEx<=0, execute<=0.
  - sendNOP=0 (stall): same bubble as flush.
  - advance: execute<=destID; NOPEx<=regWriteID & (instID≠NOP_INST); BranchEx<=BranchID & (instID≠NOP_INST).
- IF/ID:
  - flush=1: instID<=NOP_INST.
  - stall: instID holds.
  - advance: instID<=instIn.
- pcWrite is combinational: pcWrite = sendNOP | flush. Flush overrides stall because the redirected PC must load.
- Stall counting:
  - Stall cycle = sendNOP=0 & flush=0.
  - Each stall cycle increments stallCycles, saturating at 16'hFFFF.
  - Run counter (3-bit, saturating at 7) increments on each stall cycle and clears on any non-stall cycle.
  - When the run counter would exceed MAX_STALL, stallErr<=1; stays set until reset.
- X on sendNOP or flush is a bench error, not a design case.

## Timing
- All outputs except pcWrite are registered; they change only on clk rising edge or rst_n falling edge.
- The comparator uses these registered values combinationally in the same cycle to form sendNOP. There is no combinational path from sendNOP to any registered output, only to pcWrite.
- Bubble latency: a stall in cycle N produces NOPEx=0 in N+1, NOPMem=0 in N+2 and NOPWB=0 in N+3.
- Dependent-instruction stall: a RAW hazard on an EX producer stalls exactly 3 cycles, until the producer leaves WB. A 4th consecutive stall cycle sets stallErr.
- Flush and stall together: flush wins. instID=NOP_INST next cycle, no stall counted, run counter cleared.
- Reset asserted mid-stall: all state clears immediately and pcWrite follows its inputs. First post-reset cycle presents NOP_INST, so the comparator must not stall on it.
- stallCycles wrap is forbidden; it holds at 16'hFFFF.

## Test plan
- Reset: pulse rst_n low mid-cycle → instID=16'h0800, all NOP flags 0, stallCycles=0, stallErr=0 before the next edge.
- Advance: feed writer r3 (regWriteID=1, destID=3) with sendNOP=1 → execute=3/NOPEx=1, then memory=3/NOPMem=1, then writeback=3/NOPWB=1 on successive edges.
- Stall: hold sendNOP=0 for 3 cycles with instIn changing → instID held, pcWrite=0, three bubbles (NOPEx=0) enter EX, stallCycles=3, stallErr=0.
- Over-stall: sendNOP=0 for 4 consecutive cycles → stallErr=1 after the 4th edge, remains 1 after sendNOP returns high.
- Flush+stall: flush=1, sendNOP=0 same cycle → pcWrite=1, instID=16'h0800, NOPEx=0, BranchEx=0, stallCycles unchanged.
- Branch tracking: instID=non-NOP with BranchID=1, advance → BranchEx=1 one cycle; with instID=16'h0800 and BranchID=1 → BranchEx=0.
